// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- BIST sequencer for the tile's single-port SRAM.
// On an accepted start it drives every memory operation of the six March C-
// elements, compares each read against the expected background, and reports
// done / sticky fail / first failing address / saturating failure count.
// Optional single-row repair decision is built when MBIST_REPAIR_EN is defined.
module mbist_march_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [3:0]        fail_count,
  output logic [1:0]        dbg_state
`ifdef MBIST_REPAIR_EN
  ,
  output logic              repair_valid,
  output logic [ADDR_W-1:0] repair_addr,
  output logic              unrepairable
`endif
);

  // Memory port protocol: exactly one of mem_we / mem_re is high in every RUN
  // cycle and both are low otherwise. A write commits mem_wdata to mem_addr at
  // the end of its cycle; a read returns mem_rdata in the following cycle. The
  // memory has no back-pressure, so every strobe is accepted in its cycle.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic              PH_READ   = 1'b0;
  localparam logic              PH_WRITE  = 1'b1;
  localparam logic [2:0]        LAST_ELEM = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [3:0]        CNT_MAX   = 4'd15;

  state_t            state;
  logic [2:0]        elem;
  logic              phase;

  // Pending compare: describes the read issued in the previous cycle.
  logic              cmp_valid;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;

  logic [2:0]        elem_inc;
  logic [2:0]        nxt_elem;
  logic              nxt_phase;
  logic [ADDR_W-1:0] nxt_addr;
  logic              addr_last;
  logic              last_op;
  logic              miscmp;

`ifdef MBIST_REPAIR_EN
  logic              multi_fail;
  logic              second_addr;
`endif

  // M0 is the only element without a read.
  function automatic logic elem_has_read(input logic [2:0] e);
    return e != 3'd0;
  endfunction

  // M5 is the only element without a write.
  function automatic logic elem_has_write(input logic [2:0] e);
    return e != LAST_ELEM;
  endfunction

  // M3 and M4 walk the address space downwards.
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Background expected by the element's read: ones in M2 and M4.
  function automatic logic elem_rd_one(input logic [2:0] e);
    return (e == 3'd2) || (e == 3'd4);
  endfunction

  // Background written by the element's write: ones in M1 and M3.
  function automatic logic elem_wr_one(input logic [2:0] e);
    return (e == 3'd1) || (e == 3'd3);
  endfunction

  assign dbg_state = state;

  // Next operation after the one currently on the memory port.
  always_comb begin
    elem_inc  = elem + 3'd1;
    nxt_elem  = elem;
    nxt_phase = phase;
    nxt_addr  = mem_addr;
    last_op   = 1'b0;
    addr_last = elem_down(elem) ? (mem_addr == '0) : (mem_addr == ADDR_MAX);
    if ((phase == PH_READ) && elem_has_write(elem)) begin
      nxt_phase = PH_WRITE;
    end else if (addr_last) begin
      if (elem == LAST_ELEM) begin
        last_op = 1'b1;
      end else begin
        nxt_elem  = elem_inc;
        nxt_addr  = elem_down(elem_inc) ? ADDR_MAX : '0;
        nxt_phase = elem_has_read(elem_inc) ? PH_READ : PH_WRITE;
      end
    end else begin
      nxt_addr  = elem_down(elem) ? (mem_addr - ADDR_W'(1)) : (mem_addr + ADDR_W'(1));
      nxt_phase = elem_has_read(elem) ? PH_READ : PH_WRITE;
    end
  end

  // Read-data compare for the read issued last cycle.
  always_comb begin
    miscmp = cmp_valid && (mem_rdata != cmp_exp);
`ifdef MBIST_REPAIR_EN
    second_addr = miscmp && fail && (cmp_addr != fail_addr);
`endif
  end

  // Controller FSM, memory port, compare pipeline and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      elem         <= 3'd0;
      phase        <= PH_WRITE;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      mem_re       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
      fail_addr    <= '0;
      fail_count   <= 4'd0;
      cmp_valid    <= 1'b0;
      cmp_exp      <= '0;
      cmp_addr     <= '0;
`ifdef MBIST_REPAIR_EN
      multi_fail   <= 1'b0;
      repair_valid <= 1'b0;
      repair_addr  <= '0;
      unrepairable <= 1'b0;
`endif
    end else begin
      // The read on the port this cycle is compared next cycle.
      cmp_valid <= mem_re;
      cmp_exp   <= {DATA_W{elem_rd_one(elem)}};
      cmp_addr  <= mem_addr;

      if (miscmp) begin
        if (fail_count != CNT_MAX) begin
          fail_count <= fail_count + 4'd1;
        end
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= cmp_addr;
        end
`ifdef MBIST_REPAIR_EN
        if (second_addr) begin
          multi_fail <= 1'b1;
        end
`endif
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_RUN;
            busy         <= 1'b1;
            done         <= 1'b0;
            fail         <= 1'b0;
            fail_addr    <= '0;
            fail_count   <= 4'd0;
            elem         <= 3'd0;
            phase        <= PH_WRITE;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b1;
            mem_re       <= 1'b0;
`ifdef MBIST_REPAIR_EN
            multi_fail   <= 1'b0;
            repair_valid <= 1'b0;
            repair_addr  <= '0;
            unrepairable <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (last_op) begin
            state  <= S_DRAIN;
            mem_we <= 1'b0;
            mem_re <= 1'b0;
          end else begin
            elem      <= nxt_elem;
            phase     <= nxt_phase;
            mem_addr  <= nxt_addr;
            mem_wdata <= {DATA_W{elem_wr_one(nxt_elem)}};
            mem_we    <= nxt_phase;
            mem_re    <= ~nxt_phase;
          end
        end
        S_DRAIN: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
`ifdef MBIST_REPAIR_EN
          // Fold in the final compare, which is resolved in this same cycle.
          repair_valid <= (fail || miscmp) && !(multi_fail || second_addr);
          unrepairable <= multi_fail || second_addr;
          repair_addr  <= fail ? fail_addr : (miscmp ? cmp_addr : '0);
`endif
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: bench for the March C- BIST sequencer with a
// synchronous-read memory model and per-address stuck-at fault masks.
module tb_mbist_march_ctrl;

  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 8;
  localparam int N           = 16;
  localparam int BUSY_CYCLES = 161;
  localparam int MAX_CYCLES  = 500;
  localparam int NO_EVENT    = -10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [3:0]        fail_count;
  logic [1:0]        dbg_state;
`ifdef MBIST_REPAIR_EN
  logic              repair_valid;
  logic [ADDR_W-1:0] repair_addr;
  logic              unrepairable;
`endif

  logic [DATA_W-1:0] mem      [N];
  logic [DATA_W-1:0] sa0_mask [N];
  logic [DATA_W-1:0] sa1_mask [N];

  // Scoreboard entry: {we, re, addr, wdata (writes only)}.
  logic [13:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  // March C- table, one bit per element M0..M5.
  bit [5:0] tb_has_r = 6'b111110;
  bit [5:0] tb_has_w = 6'b011111;
  bit [5:0] tb_down  = 6'b011000;
  bit [5:0] tb_wbg   = 6'b001010;

  mbist_march_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .fail_addr    (fail_addr),
    .fail_count   (fail_count),
    .dbg_state    (dbg_state)
`ifdef MBIST_REPAIR_EN
    ,
    .repair_valid (repair_valid),
    .repair_addr  (repair_addr),
    .unrepairable (unrepairable)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Single-port SRAM model: read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= (mem[mem_addr] & ~sa0_mask[mem_addr]) | sa1_mask[mem_addr];
  end

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      sa0_mask[i] = '0;
      sa1_mask[i] = '0;
    end
  endtask

  // Expected port sequence of one complete run.
  task automatic push_march_ops();
    logic [ADDR_W-1:0] a;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = tb_down[e] ? ADDR_W'(N - 1 - i) : ADDR_W'(i);
        if (tb_has_r[e]) exp_q.push_back({1'b0, 1'b1, a, 8'h00});
        if (tb_has_w[e]) exp_q.push_back({1'b1, 1'b0, a, (tb_wbg[e] ? 8'hFF : 8'h00)});
      end
    end
  endtask

  // Pulse start; returns at the negedge of run cycle 1.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Scoreboard consumer: pops one expected op per busy cycle. Optionally
  // pulses start or raises rst at a given run cycle (reset ends the walk).
  task automatic run_monitor(input int pulse_at, input int reset_at, output int n);
    logic [13:0] e;
    logic [13:0] obs;
    n = 0;
    while (busy === 1'b1 && n < MAX_CYCLES) begin
      n++;
      obs = {mem_we, mem_re, mem_addr, (mem_we ? mem_wdata : 8'h00)};
      checks++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL op_seq cycle %0d: got we=%0b re=%0b addr=%0d wdata=%h, expected we=%0b re=%0b addr=%0d wdata=%h",
                   n, obs[13], obs[12], obs[11:8], obs[7:0], e[13], e[12], e[11:8], e[7:0]);
        end
      end else if ({mem_we, mem_re} !== 2'b00) begin
        errors++;
        $display("FAIL drain_port cycle %0d: got we=%0b re=%0b, expected 0 0", n, mem_we, mem_re);
      end
      if (n == pulse_at) start = 1'b1;
      else if (n == pulse_at + 1) start = 1'b0;
      if (n == reset_at) begin
        rst = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (n >= MAX_CYCLES) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy still high after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    clear_faults();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, fail, fail_addr, fail_count, mem_we, mem_re, mem_addr, mem_wdata, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b done=%0b fail=%0b fail_addr=%0d cnt=%0d we=%0b re=%0b addr=%0d wdata=%h state=%0d, expected all 0",
               busy, done, fail, fail_addr, fail_count, mem_we, mem_re, mem_addr, mem_wdata, dbg_state);
    end
`ifdef MBIST_REPAIR_EN
    checks++;
    if ({repair_valid, repair_addr, unrepairable} !== '0) begin
      errors++;
      $display("FAIL reset_repair: rv=%0b ra=%0d unrep=%0b, expected 0", repair_valid, repair_addr, unrepairable);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fault_free_run();
    int n;
    clear_faults();
    push_march_ops();
    pulse_start();
    run_monitor(NO_EVENT, NO_EVENT, n);
    checks++;
    if (n !== BUSY_CYCLES) begin errors++; $display("FAIL ff_busy_len: got %0d, expected %0d", n, BUSY_CYCLES); end
    checks++;
    if ({done, fail, fail_count} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL ff_status: done=%0b fail=%0b cnt=%0d, expected 1 0 0", done, fail, fail_count);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ff_ops_left: got %0d, expected 0", exp_q.size()); end
    exp_q.delete();
`ifdef MBIST_REPAIR_EN
    checks++;
    if ({repair_valid, repair_addr, unrepairable} !== '0) begin
      errors++;
      $display("FAIL ff_repair: rv=%0b ra=%0d unrep=%0b, expected 0", repair_valid, repair_addr, unrepairable);
    end
`endif
    repeat (2) @(negedge clk);
    checks++;
    if ({done, busy, mem_we, mem_re} !== 4'b1000) begin
      errors++;
      $display("FAIL ff_done_hold: done=%0b busy=%0b we=%0b re=%0b, expected 1 0 0 0", done, busy, mem_we, mem_re);
    end
  endtask

  task automatic test_stuck_at_0();
    int n;
    clear_faults();
    sa0_mask[5] = 8'h08;
    push_march_ops();
    pulse_start();
    run_monitor(NO_EVENT, NO_EVENT, n);
    checks++;
    if (n !== BUSY_CYCLES) begin errors++; $display("FAIL sa0_busy_len: got %0d, expected %0d", n, BUSY_CYCLES); end
    checks++;
    if ({done, fail, fail_addr, fail_count} !== {1'b1, 1'b1, 4'd5, 4'd2}) begin
      errors++;
      $display("FAIL sa0_status: done=%0b fail=%0b fail_addr=%0d cnt=%0d, expected 1 1 5 2", done, fail, fail_addr, fail_count);
    end
    exp_q.delete();
`ifdef MBIST_REPAIR_EN
    checks++;
    if ({repair_valid, repair_addr, unrepairable} !== {1'b1, 4'd5, 1'b0}) begin
      errors++;
      $display("FAIL sa0_repair: rv=%0b ra=%0d unrep=%0b, expected 1 5 0", repair_valid, repair_addr, unrepairable);
    end
`endif
  endtask

  task automatic test_stuck_at_1_pair();
    int n;
    clear_faults();
    sa1_mask[2] = 8'h01;
    sa1_mask[9] = 8'h01;
    push_march_ops();
    pulse_start();
    run_monitor(NO_EVENT, NO_EVENT, n);
    checks++;
    if (n !== BUSY_CYCLES) begin errors++; $display("FAIL sa1_busy_len: got %0d, expected %0d", n, BUSY_CYCLES); end
    checks++;
    if ({done, fail, fail_addr, fail_count} !== {1'b1, 1'b1, 4'd2, 4'd6}) begin
      errors++;
      $display("FAIL sa1_status: done=%0b fail=%0b fail_addr=%0d cnt=%0d, expected 1 1 2 6", done, fail, fail_addr, fail_count);
    end
    exp_q.delete();
`ifdef MBIST_REPAIR_EN
    checks++;
    if ({repair_valid, unrepairable} !== 2'b01) begin
      errors++;
      $display("FAIL sa1_repair: rv=%0b unrep=%0b, expected 0 1", repair_valid, unrepairable);
    end
`endif
  endtask

  task automatic test_reset_mid_run();
    int n;
    clear_faults();
    push_march_ops();
    pulse_start();
    run_monitor(NO_EVENT, 50, n);
    checks++;
    if (n !== 50) begin errors++; $display("FAIL rmr_reached: got cycle %0d, expected 50", n); end
    @(negedge clk);
    checks++;
    if ({busy, done, fail, fail_addr, fail_count, mem_we, mem_re, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL rmr_outputs: busy=%0b done=%0b fail=%0b cnt=%0d we=%0b re=%0b addr=%0d wdata=%h, expected all 0",
               busy, done, fail, fail_count, mem_we, mem_re, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    exp_q.delete();
    push_march_ops();
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rmr_start_accept: busy=%0b, expected 1", busy); end
    run_monitor(NO_EVENT, NO_EVENT, n);
    checks++;
    if (n !== BUSY_CYCLES) begin errors++; $display("FAIL rmr_busy_len: got %0d, expected %0d", n, BUSY_CYCLES); end
    checks++;
    if ({done, fail, fail_count} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL rmr_status: done=%0b fail=%0b cnt=%0d, expected 1 0 0", done, fail, fail_count);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int n;
    clear_faults();
    sa0_mask[5] = 8'h08;
    // Run A: start pulsed again at run cycle 30 must be ignored.
    push_march_ops();
    pulse_start();
    run_monitor(30, NO_EVENT, n);
    checks++;
    if (n !== BUSY_CYCLES) begin errors++; $display("FAIL b2b_ignore_len: got %0d, expected %0d", n, BUSY_CYCLES); end
    checks++;
    if ({done, fail_count} !== {1'b1, 4'd2}) begin
      errors++;
      $display("FAIL b2b_a_status: done=%0b cnt=%0d, expected 1 2", done, fail_count);
    end
    exp_q.delete();
    // Run B: start held high through DONE.
    push_march_ops();
    start = 1'b1;
    @(negedge clk);
    run_monitor(NO_EVENT, NO_EVENT, n);
    checks++;
    if (n !== BUSY_CYCLES) begin errors++; $display("FAIL b2b_b_len: got %0d, expected %0d", n, BUSY_CYCLES); end
    checks++;
    if ({done, fail, fail_count} !== {1'b1, 1'b1, 4'd2}) begin
      errors++;
      $display("FAIL b2b_b_done: done=%0b fail=%0b cnt=%0d, expected 1 1 2", done, fail, fail_count);
    end
    exp_q.delete();
    // Run C follows immediately after the single DONE cycle.
    push_march_ops();
    @(negedge clk);
    checks++;
    if ({busy, done, fail, fail_count, mem_we, mem_addr} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL b2b_restart: busy=%0b done=%0b fail=%0b cnt=%0d we=%0b addr=%0d, expected 1 0 0 0 1 0",
               busy, done, fail, fail_count, mem_we, mem_addr);
    end
    start = 1'b0;
    run_monitor(NO_EVENT, NO_EVENT, n);
    checks++;
    if (n !== BUSY_CYCLES) begin errors++; $display("FAIL b2b_c_len: got %0d, expected %0d", n, BUSY_CYCLES); end
    checks++;
    if ({done, fail, fail_addr, fail_count} !== {1'b1, 1'b1, 4'd5, 4'd2}) begin
      errors++;
      $display("FAIL b2b_c_status: done=%0b fail=%0b fail_addr=%0d cnt=%0d, expected 1 1 5 2", done, fail, fail_addr, fail_count);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_fault_free_run();
    repeat ($urandom_range(1, 4)) @(negedge clk);
    test_stuck_at_0();
    repeat ($urandom_range(1, 4)) @(negedge clk);
    test_stuck_at_1_pair();
    repeat ($urandom_range(1, 4)) @(negedge clk);
    test_reset_mid_run();
    repeat ($urandom_range(1, 4)) @(negedge clk);
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
